mdr_seq_alu: RTL and testbench
==============================

MDR_SEQ_ALU -- requirements
Module: mdr_seq_alu

Interface
REQ-001 The block SHALL have parameter WORD_LENGTH, default 16, giving the operand/result width; legal values are even integers 8..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begins an operation when high in IDLE or DONE.
REQ-005 The block SHALL have port load, input, 1 bit: operand strobe, acted on at its rising edge only.
REQ-006 The block SHALL have port op, input, 2 bits: 00 multiply, 01 divide, 10 square root, 11 reserved.
REQ-007 The block SHALL have port data, input, WORD_LENGTH bits: two's-complement operand value.
REQ-008 The block SHALL have port loadX, output, 1 bit: high while waiting for operand X.
REQ-009 The block SHALL have port loadY, output, 1 bit: high while waiting for operand Y.
REQ-010 The block SHALL have port busy, output, 1 bit: high during COMPUTE.
REQ-011 The block SHALL have port ready, output, 1 bit: high in DONE, result valid.
REQ-012 The block SHALL have port result, output, WORD_LENGTH bits: unsigned magnitude of product, quotient or root.
REQ-013 The block SHALL have port remainder, output, WORD_LENGTH bits: unsigned remainder magnitude (divide, sqrt), zero for multiply.
REQ-014 The block SHALL have port sign, output, 1 bit: sign of result (1 = negative).
REQ-015 The block SHALL have port error, output, 1 bit: divide-by-zero, negative sqrt, multiply overflow or reserved op.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_X, WAIT_Y, COMPUTE, DONE.
REQ-017 start high in IDLE or DONE SHALL latch op, clear ready/error and move to WAIT_X on the next edge; start in any other state SHALL be ignored.
REQ-018 load SHALL be edge-detected internally (registered previous value), so a load held high for many cycles captures exactly one operand.
REQ-019 A load rising edge in WAIT_X SHALL capture data as X; the FSM moves to WAIT_Y for op 00/01, and to COMPUTE for op 10.
REQ-020 A load rising edge in WAIT_Y SHALL capture data as Y and move to COMPUTE.
REQ-021 A load rising edge in IDLE, COMPUTE or DONE SHALL be ignored.
REQ-022 Multiply SHALL be iterative shift-add on |X|,|Y|, taking WORD_LENGTH cycles in COMPUTE; sign = sign(X) XOR sign(Y), forced to 0 when the product is zero.
REQ-023 If |X|*|Y| > 2^WORD_LENGTH-1, multiply SHALL set error=1 and present the low WORD_LENGTH bits of the product on result.
REQ-024 Divide SHALL be restoring division of |X| by |Y|, taking WORD_LENGTH cycles; quotient -> result, |X| mod |Y| -> remainder, sign = sign(X) XOR sign(Y), forced to 0 when the quotient is zero.
REQ-025 Divide with Y=0 SHALL spend 1 cycle in COMPUTE and then give error=1, result all ones, remainder=|X|, sign=0.
REQ-026 Square root SHALL be a digit-by-digit integer root of X, taking WORD_LENGTH/2 cycles; result=floor(sqrt(X)), remainder=X-result^2, sign=0.
REQ-027 Square root with X negative SHALL spend 1 cycle in COMPUTE and then give error=1, result=0, remainder=0.
REQ-028 op 11 SHALL spend 1 cycle in COMPUTE and then give error=1, result=0, remainder=0, sign=0.
REQ-029 -2^(WORD_LENGTH-1) SHALL be accepted as an operand; its magnitude 2^(WORD_LENGTH-1) is representable unsigned.
REQ-030 On leaving COMPUTE, the FSM SHALL enter DONE; result, remainder, sign and error SHALL update on the same edge as ready rises.
REQ-031 In DONE, ready and all outputs SHALL stay stable until start is asserted.
REQ-032 loadX, loadY, busy and ready SHALL be Moore outputs; exactly one is high outside IDLE, and none is high in IDLE.

Reset
REQ-033 reset low SHALL, asynchronously and in any state including mid-COMPUTE, force IDLE and clear all outputs and internal operand, counter and load-edge registers to 0.
REQ-034 After reset is released, the first start SHALL behave per REQ-017; load must fall and rise again before a capture.

Verification (WORD_LENGTH=16)
REQ-035 op=00, X=2, Y=40 -> ready after 16 COMPUTE cycles, result=80, remainder=0, sign=0, error=0.
REQ-036 op=01, X=2132, Y=40 -> result=53, remainder=12, error=0; then start, op=01, X=300, Y=100 -> result=3, remainder=0.
REQ-037 op=00, X=-7, Y=6 -> result=42, sign=1; op=00, X=300, Y=300 -> error=1, result=0x5F90.
REQ-038 op=10, X=1000 -> ready after 8 COMPUTE cycles, result=31, remainder=39; op=10, X=-4 -> error=1, result=0.
REQ-039 op=01, X=55, Y=0 -> error=1, result=0xFFFF, remainder=55; load held high for 10 cycles in WAIT_X -> only X captured, FSM stays in WAIT_Y.
REQ-040 reset low mid-COMPUTE of a divide -> all outputs 0 immediately and FSM in IDLE; a following op=00, X=3, Y=5 -> result=15.

Source files
------------

// File: rtl/mdr_seq_alu.sv
// rtl/mdr_seq_alu.sv - sequential multiply / divide / square-root unit with load-strobed operands
// Operands arrive one per load rising edge; results are registered and held until the next start.
module mdr_seq_alu #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   load,
    input  logic [1:0]             op,
    input  logic [WORD_LENGTH-1:0] data,
    output logic                   loadX,
    output logic                   loadY,
    output logic                   busy,
    output logic                   ready,
    output logic [WORD_LENGTH-1:0] result,
    output logic [WORD_LENGTH-1:0] remainder,
    output logic                   sign,
    output logic                   error
);

    localparam int W  = WORD_LENGTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [2:0] {IDLE, WAIT_X, WAIT_Y, COMPUTE, DONE} state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic           load_q, load_d;
    logic [W-1:0]   x_mag_q, x_mag_d;
    logic           x_neg_q, x_neg_d;
    logic           y_neg_q, y_neg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mc_q, mc_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [W-1:0]   result_q, result_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           sign_q, sign_d;
    logic           error_q, error_d;

    logic           load_rise;
    logic           data_neg;
    logic [W-1:0]   data_mag;
    logic [2*W-1:0] mul_acc;
    logic [W-1:0]   div_shift;
    logic [W:0]     div_trial;
    logic           div_ge;
    logic [W-1:0]   div_rem;
    logic [W-1:0]   div_quo;
    logic [W+1:0]   sq_shift;
    logic [W+2:0]   sq_diff;
    logic           sq_ge;
    logic [W+1:0]   sq_rem;
    logic [W-1:0]   sq_root;

    assign load_rise = load & ~load_q;
    assign data_neg  = data[W-1];
    assign data_mag  = data_neg ? (~data + {{(W-1){1'b0}}, 1'b1}) : data;

    // acc holds the product (multiply) or the partial remainder (divide, sqrt);
    // mc holds the shifted multiplicand, the divisor, or the developing root.
    assign mul_acc   = sh_q[0] ? (acc_q + mc_q) : acc_q;
    assign div_shift = {acc_q[W-2:0], sh_q[W-1]};
    assign div_trial = {1'b0, div_shift} - {1'b0, mc_q[W-1:0]};
    assign div_ge    = ~div_trial[W];
    assign div_rem   = div_ge ? div_trial[W-1:0] : div_shift;
    assign div_quo   = {sh_q[W-2:0], div_ge};
    assign sq_shift  = {acc_q[W-1:0], sh_q[W-1:W-2]};
    assign sq_diff   = {1'b0, sq_shift} - {1'b0, mc_q[W-1:0], 2'b01};
    assign sq_ge     = ~sq_diff[W+2];
    assign sq_rem    = sq_ge ? sq_diff[W+1:0] : sq_shift;
    assign sq_root   = {mc_q[W-2:0], sq_ge};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        load_d   = load;
        x_mag_d  = x_mag_q;
        x_neg_d  = x_neg_q;
        y_neg_d  = y_neg_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mc_d     = mc_q;
        sh_d     = sh_q;
        result_d = result_q;
        rem_d    = rem_q;
        sign_d   = sign_q;
        error_d  = error_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = WAIT_X;
                    op_d    = op;
                    error_d = 1'b0;
                end
            end
            WAIT_X: begin
                if (load_rise) begin
                    x_neg_d = data_neg;
                    x_mag_d = data_mag;
                    if (op_q == 2'b00 || op_q == 2'b01) begin
                        state_d = WAIT_Y;
                    end else begin
                        state_d = COMPUTE;
                        cnt_d   = '0;
                        acc_d   = '0;
                        mc_d    = '0;
                        sh_d    = data;
                    end
                end
            end
            WAIT_Y: begin
                if (load_rise) begin
                    y_neg_d = data_neg;
                    state_d = COMPUTE;
                    cnt_d   = '0;
                    acc_d   = '0;
                    if (op_q == 2'b00) begin
                        mc_d = {{W{1'b0}}, x_mag_q};
                        sh_d = data_mag;
                    end else begin
                        mc_d = {{W{1'b0}}, data_mag};
                        sh_d = x_mag_q;
                    end
                end
            end
            COMPUTE: begin
                cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                case (op_q)
                    2'b00: begin
                        acc_d = mul_acc;
                        mc_d  = {mc_q[2*W-2:0], 1'b0};
                        sh_d  = {1'b0, sh_q[W-1:1]};
                        if (cnt_q == CW'(W - 1)) begin
                            state_d  = DONE;
                            result_d = mul_acc[W-1:0];
                            rem_d    = '0;
                            error_d  = |mul_acc[2*W-1:W];
                            sign_d   = (x_neg_q ^ y_neg_q) & (|mul_acc);
                        end
                    end
                    2'b01: begin
                        if (mc_q == '0) begin
                            state_d  = DONE;
                            result_d = '1;
                            rem_d    = x_mag_q;
                            sign_d   = 1'b0;
                            error_d  = 1'b1;
                        end else begin
                            acc_d = {{W{1'b0}}, div_rem};
                            sh_d  = div_quo;
                            if (cnt_q == CW'(W - 1)) begin
                                state_d  = DONE;
                                result_d = div_quo;
                                rem_d    = div_rem;
                                error_d  = 1'b0;
                                sign_d   = (x_neg_q ^ y_neg_q) & (|div_quo);
                            end
                        end
                    end
                    2'b10: begin
                        if (x_neg_q) begin
                            state_d  = DONE;
                            result_d = '0;
                            rem_d    = '0;
                            sign_d   = 1'b0;
                            error_d  = 1'b1;
                        end else begin
                            acc_d = {{(W-2){1'b0}}, sq_rem};
                            mc_d  = {{W{1'b0}}, sq_root};
                            sh_d  = {sh_q[W-3:0], 2'b00};
                            if (cnt_q == CW'(W / 2 - 1)) begin
                                state_d  = DONE;
                                result_d = sq_root;
                                rem_d    = sq_rem[W-1:0];
                                sign_d   = 1'b0;
                                error_d  = 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_d  = DONE;
                        result_d = '0;
                        rem_d    = '0;
                        sign_d   = 1'b0;
                        error_d  = 1'b1;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            load_q   <= 1'b0;
            x_mag_q  <= '0;
            x_neg_q  <= 1'b0;
            y_neg_q  <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mc_q     <= '0;
            sh_q     <= '0;
            result_q <= '0;
            rem_q    <= '0;
            sign_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            load_q   <= load_d;
            x_mag_q  <= x_mag_d;
            x_neg_q  <= x_neg_d;
            y_neg_q  <= y_neg_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            sign_q   <= sign_d;
            error_q  <= error_d;
        end
    end

    assign loadX     = (state_q == WAIT_X);
    assign loadY     = (state_q == WAIT_Y);
    assign busy      = (state_q == COMPUTE);
    assign ready     = (state_q == DONE);
    assign result    = result_q;
    assign remainder = rem_q;
    assign sign      = sign_q;
    assign error     = error_q;

endmodule

// File: tb/tb_mdr_seq_alu.sv
// tb/tb_mdr_seq_alu.sv - directed and random checks of mdr_seq_alu with an expected-result queue
module tb_mdr_seq_alu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        load = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] data = 16'h0;
    logic        loadX, loadY, busy, ready, sign, error;
    logic [15:0] result, remainder;

    mdr_seq_alu #(.WORD_LENGTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .load(load), .op(op), .data(data),
        .loadX(loadX), .loadY(loadY), .busy(busy), .ready(ready),
        .result(result), .remainder(remainder), .sign(sign), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [15:0] rem;
        logic        sgn;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] res, input logic [15:0] rem,
                                input logic sgn, input logic err, input int cyc);
        exp_t e;
        e.res = res; e.rem = rem; e.sgn = sgn; e.err = err; e.cyc = cyc;
        return e;
    endfunction

    // Reference arithmetic on plain integers.
    function automatic exp_t model(input logic [1:0] o, input int x, input int y);
        exp_t   e;
        longint ax, ay, p;
        int     r;
        ax = (x < 0) ? -longint'(x) : longint'(x);
        ay = (y < 0) ? -longint'(y) : longint'(y);
        e = mk(16'h0, 16'h0, 1'b0, 1'b0, 1);
        case (o)
            2'd0: begin
                p = ax * ay;
                e.res = p[15:0];
                e.err = (p > 65535);
                e.sgn = (p != 0) && ((x < 0) != (y < 0));
                e.cyc = 16;
            end
            2'd1: begin
                if (ay == 0) begin
                    e.err = 1'b1;
                    e.res = 16'hFFFF;
                    e.rem = ax[15:0];
                end else begin
                    p = ax / ay;
                    e.res = p[15:0];
                    p = ax % ay;
                    e.rem = p[15:0];
                    e.sgn = (e.res != 0) && ((x < 0) != (y < 0));
                    e.cyc = 16;
                end
            end
            2'd2: begin
                if (x < 0) begin
                    e.err = 1'b1;
                end else begin
                    r = 0;
                    while ((r + 1) * (r + 1) <= x) r++;
                    e.res = 16'(r);
                    e.rem = 16'(x - r * r);
                    e.cyc = 8;
                end
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic begin_op(input logic [1:0] o, input int x, input int y, input int xhold, input exp_t e);
        @(posedge clk); #1;
        start = 1'b1;
        op = o;
        @(posedge clk); #1;
        start = 1'b0;
        chk("wait_x_loadX", 32'(loadX), 32'd1);
        data = 16'(x);
        load = 1'b1;
        repeat (xhold) @(posedge clk);
        #1;
        load = 1'b0;
        if (o < 2'd2) begin
            @(posedge clk); #1;
            chk("wait_y_loadY", 32'(loadY), 32'd1);
            chk("wait_y_busy", 32'(busy), 32'd0);
            data = 16'(y);
            load = 1'b1;
            @(posedge clk); #1;
            load = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic finish_op(input string tag, input int pre);
        exp_t e;
        int   n;
        n = pre;
        e = sb.pop_front();
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 200), 32'd1);
        chk({tag, "_cycles"}, 32'(n), 32'(e.cyc));
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_result"}, 32'(result), 32'(e.res));
        chk({tag, "_remainder"}, 32'(remainder), 32'(e.rem));
        chk({tag, "_sign"}, 32'(sign), 32'(e.sgn));
        chk({tag, "_error"}, 32'(error), 32'(e.err));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_moore"}, {28'h0, loadX, loadY, busy, ready}, 32'h0);
        chk({tag, "_result"}, 32'(result), 32'h0);
        chk({tag, "_remainder"}, 32'(remainder), 32'h0);
        chk({tag, "_sign_err"}, {30'h0, sign, error}, 32'h0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;

        begin_op(2'd0, 2, 40, 1, mk(16'd80, 16'd0, 1'b0, 1'b0, 16));
        finish_op("mul_2x40", 0);
        // DONE must hold steady and ignore load pulses.
        load = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        load = 1'b0;
        chk("done_hold_ready", 32'(ready), 32'd1);
        chk("done_hold_result", 32'(result), 32'd80);

        begin_op(2'd1, 2132, 40, 1, mk(16'd53, 16'd12, 1'b0, 1'b0, 16));
        finish_op("div_2132_40", 0);
        begin_op(2'd1, 300, 100, 1, mk(16'd3, 16'd0, 1'b0, 1'b0, 16));
        finish_op("div_300_100", 0);

        // start pulsed during COMPUTE must be ignored.
        begin_op(2'd0, -7, 6, 1, mk(16'd42, 16'd0, 1'b1, 1'b0, 16));
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_ignored_busy", 32'(busy), 32'd1);
        finish_op("mul_m7x6", 2);

        begin_op(2'd0, 300, 300, 1, mk(16'h5F90, 16'd0, 1'b0, 1'b1, 16));
        finish_op("mul_ovf", 0);
        begin_op(2'd2, 1000, 0, 1, mk(16'd31, 16'd39, 1'b0, 1'b0, 8));
        finish_op("sqrt_1000", 0);
        begin_op(2'd2, -4, 0, 1, mk(16'd0, 16'd0, 1'b0, 1'b1, 1));
        finish_op("sqrt_neg", 0);
        begin_op(2'd1, 55, 0, 10, mk(16'hFFFF, 16'd55, 1'b0, 1'b1, 1));
        finish_op("div_by_zero", 0);

        begin_op(2'd1, -32768, 3, 1, model(2'd1, -32768, 3));
        finish_op("div_min_3", 0);
        begin_op(2'd0, -32768, 1, 1, model(2'd0, -32768, 1));
        finish_op("mul_min_1", 0);
        begin_op(2'd2, 32767, 0, 1, model(2'd2, 32767, 0));
        finish_op("sqrt_max", 0);
        begin_op(2'd1, -100, -7, 1, model(2'd1, -100, -7));
        finish_op("div_neg_neg", 0);
        begin_op(2'd0, 0, -5, 1, model(2'd0, 0, -5));
        finish_op("mul_zero", 0);

        for (int i = 0; i < 4; i++) begin
            logic [1:0]  ro;
            logic [15:0] rx;
            int          x, y;
            ro = 2'($urandom_range(0, 2));
            rx = 16'($urandom);
            x = int'($signed(rx));
            y = int'($urandom_range(0, 300)) - 150;
            begin_op(ro, x, y, 1, model(ro, x, y));
            finish_op("random", 0);
        end

        // Asynchronous reset in the middle of a divide.
        begin_op(2'd1, 2132, 40, 1, model(2'd1, 2132, 40));
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        void'(sb.pop_front());
        @(posedge clk); #1;
        reset = 1'b1;
        begin_op(2'd0, 3, 5, 1, mk(16'd15, 16'd0, 1'b0, 1'b0, 16));
        finish_op("mul_after_reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
